// File: rtl/mac_acc_stage.sv
// ============================================================================
//  Module   : mac_acc_stage
//  Purpose  : Saturating signed 8-bit accumulator that sums LEN addends (or
//             fewer, when in_last closes the group) and hands the result off
//             through a valid/ready output register.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_acc_stage #(
  parameter int unsigned LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sat
);

  localparam logic [7:0] C_LAST_CNT = 8'(LEN - 1);
  localparam logic [7:0] C_POS_MAX  = 8'h7F;
  localparam logic [7:0] C_NEG_MIN  = 8'h80;

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sticky_q, sticky_d;
  logic       ov_q, ov_d;
  logic [7:0] od_q, od_d;
  logic       os_q, os_d;

  logic [8:0] w_sum;
  logic       w_ovf;
  logic [7:0] w_sat;
  logic       w_close;

  // Exact 9-bit sum; the two top bits disagree exactly when it leaves int8 range.
  always_comb begin
    w_sum = {acc_q[7], acc_q} + {in_data[7], in_data};
    w_ovf = w_sum[8] ^ w_sum[7];
    if (w_ovf) begin
      w_sat = w_sum[8] ? C_NEG_MIN : C_POS_MAX;
    end else begin
      w_sat = w_sum[7:0];
    end
    w_close = in_last || (cnt_q == C_LAST_CNT);
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    ov_d     = ov_q;
    od_d     = od_q;
    os_d     = os_q;
    in_ready = 1'b0;

    case (state_q)
      ST_ACC: begin
        in_ready = !clr;
        if (clr) begin
          acc_d    = 8'd0;
          cnt_d    = 8'd0;
          sticky_d = 1'b0;
        end else if (in_valid) begin
          if (w_close) begin
            od_d     = w_sat;
            os_d     = sticky_q | w_ovf;
            ov_d     = 1'b1;
            acc_d    = 8'd0;
            cnt_d    = 8'd0;
            sticky_d = 1'b0;
            state_d  = ST_OUT;
          end else begin
            acc_d    = w_sat;
            cnt_d    = cnt_q + 8'd1;
            sticky_d = sticky_q | w_ovf;
          end
        end
      end
      // clr is deliberately ignored here so a pending result is never dropped.
      ST_OUT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ACC;
      acc_q    <= 8'd0;
      cnt_q    <= 8'd0;
      sticky_q <= 1'b0;
      ov_q     <= 1'b0;
      od_q     <= 8'd0;
      os_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      os_q     <= os_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_sat   = os_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_acc_stage.sv
// ============================================================================
//  Module   : tb_mac_acc_stage
//  Purpose  : Directed, table-driven checks of mac_acc_stage with LEN=4.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_acc_stage;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sat;

  int n_vec;
  int n_err;

  mac_acc_stage #(.LEN(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock: inputs driven for the cycle, in_ready expected
  // before the edge, output register contents expected after it.
  typedef struct {
    logic       clr;
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       ordy;
    logic       e_rdy;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_os;
  } vec_t;

  function automatic vec_t mk(input logic c, input logic v, input logic [7:0] d,
                              input logic l, input logic ordy, input logic e_rdy,
                              input logic e_ov, input logic [7:0] e_od,
                              input logic e_os);
    vec_t r;
    r.clr = c; r.v = v; r.d = d; r.l = l; r.ordy = ordy;
    r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_od = e_od; r.e_os = e_os;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    clr       = t.clr;
    in_valid  = t.v;
    in_data   = t.d;
    in_last   = t.l;
    out_ready = t.ordy;
    #1;
    chk("in_ready", idx, {7'd0, in_ready}, {7'd0, t.e_rdy});
    @(posedge clk);
    #1;
    chk("out_valid", idx, {7'd0, out_valid}, {7'd0, t.e_ov});
    chk("out_data", idx, out_data, t.e_od);
    chk("out_sat", idx, {7'd0, out_sat}, {7'd0, t.e_os});
    n_vec++;
  endtask

  vec_t tab[32];
  vec_t tab2[6];

  initial begin
    n_vec = 0;
    n_err = 0;

    //               clr v  d      l  ordy rdy ov od     os
    // 10+20+30+40 closes on count with no in_last
    tab[0]  = mk(0, 1, 8'd10,  0, 0, 1, 0, 8'h00, 0);
    tab[1]  = mk(0, 1, 8'd20,  0, 0, 1, 0, 8'h00, 0);
    tab[2]  = mk(0, 1, 8'd30,  0, 0, 1, 0, 8'h00, 0);
    tab[3]  = mk(0, 1, 8'd40,  0, 0, 1, 1, 8'd100, 0);
    tab[4]  = mk(0, 0, 8'd0,   0, 1, 0, 0, 8'd100, 0);
    // 100+50 clamps to 127
    tab[5]  = mk(0, 1, 8'd100, 0, 0, 1, 0, 8'd100, 0);
    tab[6]  = mk(0, 1, 8'd50,  1, 0, 1, 1, 8'h7F, 1);
    tab[7]  = mk(0, 0, 8'd0,   0, 1, 0, 0, 8'h7F, 1);
    // -100-100 clamps to -128, then +50 = -78
    tab[8]  = mk(0, 1, 8'h9C,  0, 0, 1, 0, 8'h7F, 1);
    tab[9]  = mk(0, 1, 8'h9C,  0, 0, 1, 0, 8'h7F, 1);
    tab[10] = mk(0, 1, 8'd50,  1, 0, 1, 1, 8'hB2, 1);
    // backpressure for 5 cycles with beats offered
    tab[11] = mk(0, 1, 8'd7,   1, 0, 0, 1, 8'hB2, 1);
    tab[12] = mk(0, 1, 8'd7,   1, 0, 0, 1, 8'hB2, 1);
    tab[13] = mk(0, 1, 8'd7,   1, 0, 0, 1, 8'hB2, 1);
    tab[14] = mk(0, 1, 8'd7,   1, 0, 0, 1, 8'hB2, 1);
    tab[15] = mk(0, 1, 8'd7,   1, 0, 0, 1, 8'hB2, 1);
    tab[16] = mk(0, 0, 8'd0,   0, 1, 0, 0, 8'hB2, 1);
    // single-beat group right after handoff; sticky must have cleared
    tab[17] = mk(0, 1, 8'd3,   1, 0, 1, 1, 8'd3,  0);
    tab[18] = mk(0, 0, 8'd0,   0, 1, 0, 0, 8'd3,  0);
    // 60+100 saturates, clr wipes acc and sticky, then 5 with last
    tab[19] = mk(0, 1, 8'd60,  0, 0, 1, 0, 8'd3,  0);
    tab[20] = mk(0, 1, 8'd100, 0, 0, 1, 0, 8'd3,  0);
    tab[21] = mk(1, 1, 8'd60,  0, 0, 0, 0, 8'd3,  0);
    tab[22] = mk(0, 1, 8'd5,   1, 0, 1, 1, 8'd5,  0);
    // clr while holding a result is ignored
    tab[23] = mk(1, 0, 8'd0,   0, 0, 0, 1, 8'd5,  0);
    tab[24] = mk(1, 0, 8'd0,   0, 1, 0, 0, 8'd5,  0);
    // clr also restarts the count: four more beats needed after it
    tab[25] = mk(0, 1, 8'd1,   0, 0, 1, 0, 8'd5,  0);
    tab[26] = mk(1, 1, 8'd1,   0, 0, 0, 0, 8'd5,  0);
    tab[27] = mk(0, 1, 8'd1,   0, 0, 1, 0, 8'd5,  0);
    tab[28] = mk(0, 1, 8'd1,   0, 0, 1, 0, 8'd5,  0);
    tab[29] = mk(0, 1, 8'd1,   0, 0, 1, 0, 8'd5,  0);
    tab[30] = mk(0, 1, 8'd1,   0, 0, 1, 1, 8'd4,  0);
    tab[31] = mk(0, 0, 8'd0,   0, 1, 0, 0, 8'd4,  0);

    // after a mid-group reset, a full LEN-beat group of 5s is needed
    tab2[0] = mk(0, 1, 8'd5,   0, 0, 1, 0, 8'd0,  0);
    tab2[1] = mk(0, 1, 8'd5,   0, 0, 1, 0, 8'd0,  0);
    tab2[2] = mk(0, 1, 8'd5,   0, 0, 1, 0, 8'd0,  0);
    tab2[3] = mk(0, 1, 8'd5,   0, 0, 1, 1, 8'd20, 0);
    tab2[4] = mk(0, 0, 8'd0,   0, 0, 0, 1, 8'd20, 0);
    tab2[5] = mk(0, 1, 8'h80,  1, 0, 0, 1, 8'd20, 0);

    clr = 0; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_out_valid", 0, {7'd0, out_valid}, 8'd0);
    chk("rst_out_data", 0, out_data, 8'd0);
    chk("rst_out_sat", 0, {7'd0, out_sat}, 8'd0);
    chk("rst_in_ready", 0, {7'd0, in_ready}, 8'd1);
    n_vec++;

    for (int i = 0; i < 32; i++) apply(tab[i], i + 1);

    // Two beats into a group, then an asynchronous reset away from any edge.
    apply(mk(0, 1, 8'd70, 0, 0, 1, 0, 8'd4, 0), 100);
    apply(mk(0, 1, 8'd70, 0, 0, 1, 0, 8'd4, 0), 101);
    @(negedge clk);
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_out_data", 102, out_data, 8'd0);
    chk("async_rst_out_valid", 102, {7'd0, out_valid}, 8'd0);
    n_vec++;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) apply(tab2[i], 200 + i);

    // Reset with a result pending must drop it.
    #2;
    rst_n = 0;
    #1;
    chk("rst_in_out_valid", 300, {7'd0, out_valid}, 8'd0);
    chk("rst_in_out_data", 300, out_data, 8'd0);
    n_vec++;
    @(negedge clk);
    in_valid = 0;
    rst_n = 1;
    #1;
    chk("rst_in_out_ready", 301, {7'd0, in_ready}, 8'd1);
    n_vec++;
    apply(mk(0, 1, 8'hF6, 1, 0, 1, 1, 8'hF6, 0), 302);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
